// File: rtl/add_mul_mix_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | add_mul_mix_pkg                                                      |
// | Shared mode/state enums and counter-width helper for add_mul_mix_seq |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package add_mul_mix_pkg;

   typedef enum logic {
      MUL_SUM = 1'b0,
      SUM_MUL = 1'b1
   } mode_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL0 = 2'd1,
      MUL1 = 2'd2,
      DONE = 2'd3
   } state_e;

   // Bit counter must hold values 0..W.
   function automatic int cnt_width(input int w);
      return $clog2(w + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/add_mul_mix_seq_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | add_mul_mix_seq_if                                                   |
// | Operand/result handshake bundle; ovf exists with ADD_MUL_MIX_OVF_EN  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface add_mul_mix_seq_if #(
   parameter int W = 4
);
   logic             in_valid;
   logic             in_ready;
   logic             mode;
   logic [W-1:0]     a;
   logic [W-1:0]     b;
   logic [W-1:0]     c;
   logic [W-1:0]     d;
   logic             out_valid;
   logic             out_ready;
   logic [2*W-1:0]   result;
`ifdef ADD_MUL_MIX_OVF_EN
   logic             ovf;

   modport master (
      output in_valid, mode, a, b, c, d, out_ready,
      input  in_ready, out_valid, result, ovf
   );
   modport slave (
      input  in_valid, mode, a, b, c, d, out_ready,
      output in_ready, out_valid, result, ovf
   );
`else
   modport master (
      output in_valid, mode, a, b, c, d, out_ready,
      input  in_ready, out_valid, result
   );
   modport slave (
      input  in_valid, mode, a, b, c, d, out_ready,
      output in_ready, out_valid, result
   );
`endif
endinterface
`default_nettype wire

// File: rtl/add_mul_mix_seq_mul_step.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seq_mul_step                                                         |
// | One shift-add multiplier iteration; carry_o with ADD_MUL_MIX_OVF_EN  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module seq_mul_step #(
   parameter int W  = 4,
   parameter int CW = 3
) (
   input  logic [2*W-1:0] acc_i,
   input  logic [W-1:0]   mcand_i,
   input  logic [W-1:0]   mplr_i,
   input  logic [CW-1:0]  cnt_i,
   output logic [2*W-1:0] acc_o,
`ifdef ADD_MUL_MIX_OVF_EN
   output logic           carry_o,
`endif
   output logic [W-1:0]   mplr_o
);
   logic [2*W-1:0] w_part;

   always_comb begin
      w_part = '0;
      if (mplr_i[0]) begin
         w_part = {{W{1'b0}}, mcand_i} << cnt_i;
      end
   end

`ifdef ADD_MUL_MIX_OVF_EN
   assign {carry_o, acc_o} = {1'b0, acc_i} + {1'b0, w_part};
`else
   assign acc_o = acc_i + w_part;
`endif

   assign mplr_o = mplr_i >> 1;

endmodule
`default_nettype wire

// File: rtl/add_mul_mix_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | add_mul_mix_seq                                                      |
// | Iterative (a+b)*(c+d) / a*b+c*d; ovf port with ADD_MUL_MIX_OVF_EN    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module add_mul_mix_seq
   import add_mul_mix_pkg::*;
#(
   parameter int W = 4
) (
   input  logic               clk,
   input  logic               rst,
   add_mul_mix_seq_if.slave   bus
);
   localparam int CW = cnt_width(W);

   state_e           state_q, state_d;
   mode_e            mode_q, mode_d;
   logic [W-1:0]     mcand_q, mcand_d;
   logic [W-1:0]     mplr_q, mplr_d;
   logic [W-1:0]     c_q, c_d;
   logic [W-1:0]     d_q, d_d;
   logic [2*W-1:0]   acc_q, acc_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   logic [2*W-1:0]   w_acc_nxt;
   logic [W-1:0]     w_mplr_nxt;
   logic [W-1:0]     w_sab;
   logic [W-1:0]     w_scd;
   logic             w_last;

`ifdef ADD_MUL_MIX_OVF_EN
   logic             ovf_q, ovf_d;
   logic             w_carry;
   logic             w_cab;
   logic             w_ccd;

   assign {w_cab, w_sab} = {1'b0, bus.a} + {1'b0, bus.b};
   assign {w_ccd, w_scd} = {1'b0, bus.c} + {1'b0, bus.d};
`else
   // Sums wrap at W bits; the carry is intentionally dropped.
   assign w_sab = bus.a + bus.b;
   assign w_scd = bus.c + bus.d;
`endif

   seq_mul_step #(
      .W  (W),
      .CW (CW)
   ) u_step (
      .acc_i   (acc_q),
      .mcand_i (mcand_q),
      .mplr_i  (mplr_q),
      .cnt_i   (cnt_q),
      .acc_o   (w_acc_nxt),
`ifdef ADD_MUL_MIX_OVF_EN
      .carry_o (w_carry),
`endif
      .mplr_o  (w_mplr_nxt)
   );

   assign w_last = (cnt_q == CW'(W - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         mode_q  <= MUL_SUM;
         mcand_q <= '0;
         mplr_q  <= '0;
         c_q     <= '0;
         d_q     <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
`ifdef ADD_MUL_MIX_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         mcand_q <= mcand_d;
         mplr_q  <= mplr_d;
         c_q     <= c_d;
         d_q     <= d_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
`ifdef ADD_MUL_MIX_OVF_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      mcand_d = mcand_q;
      mplr_d  = mplr_q;
      c_d     = c_q;
      d_d     = d_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
`ifdef ADD_MUL_MIX_OVF_EN
      ovf_d   = ovf_q;
`endif
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               mode_d = mode_e'(bus.mode);
               c_d    = bus.c;
               d_d    = bus.d;
               acc_d  = '0;
               cnt_d  = '0;
               if (bus.mode == SUM_MUL) begin
                  mcand_d = bus.a;
                  mplr_d  = bus.b;
               end else begin
                  mcand_d = w_sab;
                  mplr_d  = w_scd;
               end
`ifdef ADD_MUL_MIX_OVF_EN
               ovf_d = (bus.mode == MUL_SUM) && (w_cab || w_ccd);
`endif
               state_d = MUL0;
            end
         end
         MUL0: begin
            acc_d  = w_acc_nxt;
            mplr_d = w_mplr_nxt;
            cnt_d  = cnt_q + CW'(1);
            if (w_last) begin
               if (mode_q == SUM_MUL) begin
                  mcand_d = c_q;
                  mplr_d  = d_q;
                  cnt_d   = '0;
                  state_d = MUL1;
               end else begin
                  state_d = DONE;
               end
            end
         end
         MUL1: begin
            acc_d  = w_acc_nxt;
            mplr_d = w_mplr_nxt;
            cnt_d  = cnt_q + CW'(1);
`ifdef ADD_MUL_MIX_OVF_EN
            ovf_d  = ovf_q | w_carry;
`endif
            if (w_last) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.result    = (state_q == DONE) ? acc_q : '0;
`ifdef ADD_MUL_MIX_OVF_EN
   assign bus.ovf       = (state_q == DONE) && ovf_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_add_mul_mix_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_add_mul_mix_seq                                                   |
// | Directed self-checking bench for W=4 and W=8 instances               |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_add_mul_mix_seq;
   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;

   add_mul_mix_seq_if #(.W(4)) if4 ();
   add_mul_mix_seq_if #(.W(8)) if8 ();

   add_mul_mix_seq #(.W(4)) u_dut4 (.clk(clk), .rst(rst), .bus(if4));
   add_mul_mix_seq #(.W(8)) u_dut8 (.clk(clk), .rst(rst), .bus(if8));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Issue one W=4 operation, wait for out_valid, check latency/result/ovf.
   task automatic run4(input string tag, input logic m, input logic [3:0] a, b, c, d,
                       input logic [7:0] exp_res, input logic exp_ovf, input int lat);
      int n;
      @(negedge clk);
      check({tag, "_rdy"}, 32'(if4.in_ready), 32'd1);
      if4.in_valid = 1'b1;
      if4.mode = m;
      if4.a = a; if4.b = b; if4.c = c; if4.d = d;
      @(posedge clk);
      #1;
      if4.in_valid = 1'b0;
      if4.a = ~a; if4.b = ~b; if4.c = ~c; if4.d = ~d; if4.mode = ~m;
      n = 0;
      while (n < 40) begin
         @(posedge clk);
         n++;
         #1;
         if (if4.out_valid) break;
      end
      check({tag, "_lat"}, 32'(n), 32'(lat));
      check({tag, "_res"}, 32'(if4.result), 32'(exp_res));
`ifdef ADD_MUL_MIX_OVF_EN
      check({tag, "_ovf"}, 32'(if4.ovf), 32'(exp_ovf));
`else
      if (exp_ovf === 1'bx) check({tag, "_ovfx"}, 32'd0, 32'd1);
`endif
      if (!if4.out_ready) begin
         if4.out_ready = 1'b1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic run8(input string tag, input logic m, input logic [7:0] a, b, c, d,
                       input logic [15:0] exp_res, input logic exp_ovf, input int lat);
      int n;
      @(negedge clk);
      if8.in_valid = 1'b1;
      if8.mode = m;
      if8.a = a; if8.b = b; if8.c = c; if8.d = d;
      @(posedge clk);
      #1;
      if8.in_valid = 1'b0;
      n = 0;
      while (n < 60) begin
         @(posedge clk);
         n++;
         #1;
         if (if8.out_valid) break;
      end
      check({tag, "_lat"}, 32'(n), 32'(lat));
      check({tag, "_res"}, 32'(if8.result), 32'(exp_res));
`ifdef ADD_MUL_MIX_OVF_EN
      check({tag, "_ovf"}, 32'(if8.ovf), 32'(exp_ovf));
`else
      if (exp_ovf === 1'bx) check({tag, "_ovfx"}, 32'd0, 32'd1);
`endif
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [7:0] held;
      n_checks = 0;
      n_errors = 0;
      rst = 1'b1;
      if4.in_valid = 1'b0; if4.mode = 1'b0; if4.out_ready = 1'b1;
      if4.a = '0; if4.b = '0; if4.c = '0; if4.d = '0;
      if8.in_valid = 1'b0; if8.mode = 1'b0; if8.out_ready = 1'b1;
      if8.a = '0; if8.b = '0; if8.c = '0; if8.d = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", 32'(if4.in_ready), 32'd1);
      check("rst_out_valid", 32'(if4.out_valid), 32'd0);
      check("rst_result", 32'(if4.result), 32'd0);
`ifdef ADD_MUL_MIX_OVF_EN
      check("rst_ovf", 32'(if4.ovf), 32'd0);
`endif
      @(negedge clk);
      rst = 1'b0;

      run4("m0_basic", 1'b0, 4'd3, 4'd5, 4'd2, 4'd7, 8'h48, 1'b0, 4);
      run4("m0_wrap", 1'b0, 4'd15, 4'd1, 4'd3, 4'd4, 8'h00, 1'b1, 4);
      run4("m1_max", 1'b1, 4'd15, 4'd15, 4'd15, 4'd15, 8'hC2, 1'b1, 8);
      run4("m1_small", 1'b1, 4'd3, 4'd4, 4'd5, 4'd6, 8'h2A, 1'b0, 8);
      run4("m1_nocarry", 1'b1, 4'd15, 4'd15, 4'd1, 4'd1, 8'hE2, 1'b0, 8);
      run4("m0_zero_mplr", 1'b0, 4'd2, 4'd3, 4'd0, 4'd0, 8'h00, 1'b0, 4);

      // Stall in DONE with a competing request that must not be taken.
      if4.out_ready = 1'b0;
      run4("stall", 1'b0, 4'd1, 4'd2, 4'd3, 4'd4, 8'h15, 1'b0, 4);
      // run4 released out_ready only after sampling; redo a real stall here.
      if4.out_ready = 1'b0;
      @(negedge clk);
      if4.in_valid = 1'b1; if4.mode = 1'b0;
      if4.a = 4'd1; if4.b = 4'd2; if4.c = 4'd3; if4.d = 4'd4;
      @(posedge clk);
      #1;
      if4.in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      held = if4.result;
      check("stall_res0", 32'(held), 32'h15);
      if4.in_valid = 1'b1; if4.mode = 1'b0;
      if4.a = 4'd2; if4.b = 4'd2; if4.c = 4'd2; if4.d = 4'd2;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         check("stall_valid", 32'(if4.out_valid), 32'd1);
         check("stall_res", 32'(if4.result), 32'h15);
         check("stall_in_ready", 32'(if4.in_ready), 32'd0);
      end
      if4.in_valid = 1'b0;
      if4.out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("post_stall_idle", 32'(if4.in_ready), 32'd1);
      @(posedge clk);
      #1;
      check("no_ghost_accept", 32'(if4.in_ready), 32'd1);
      check("no_ghost_valid", 32'(if4.out_valid), 32'd0);
      run4("after_stall", 1'b0, 4'd2, 4'd2, 4'd2, 4'd2, 8'h10, 1'b0, 4);

      // Asynchronous reset in the middle of MUL0.
      @(negedge clk);
      if4.in_valid = 1'b1; if4.mode = 1'b0;
      if4.a = 4'd5; if4.b = 4'd5; if4.c = 4'd5; if4.d = 4'd5;
      @(posedge clk);
      #1;
      if4.in_valid = 1'b0;
      @(posedge clk);
      #1;
      check("mul0_busy", 32'(if4.in_ready), 32'd0);
      #2;
      rst = 1'b1;
      #1;
      check("arst_in_ready", 32'(if4.in_ready), 32'd1);
      check("arst_out_valid", 32'(if4.out_valid), 32'd0);
      check("arst_result", 32'(if4.result), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      run4("after_rst", 1'b0, 4'd1, 4'd1, 4'd1, 4'd1, 8'h04, 1'b0, 4);

      run8("w8_m0", 1'b0, 8'd200, 8'd100, 8'd10, 8'd5, 16'h0294, 1'b1, 8);
      run8("w8_m1", 1'b1, 8'd255, 8'd255, 8'd255, 8'd255, 16'hFC02, 1'b1, 16);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end
endmodule
`default_nettype wire
